// File: rtl/gpr_wb_pkg.sv
// gpr_wb_pkg
// Shared definitions for the GPR write-back unit.
//   GPR_AW / GPR_DW : register address and data widths
//   OF_REG_IDX      : GPR that receives the overflow flag (r30)
//   wb_item         : one pending write-back {rd, data, ofen, of}
//   wb_src_e        : which source owns the write port this cycle
// Optional feature: GPR_WB_BYPASS_EN (see gpr_wb.sv).
package gpr_wb_pkg;

  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;

  localparam logic [GPR_AW-1:0] OF_REG_IDX = 5'd30;

  typedef struct packed {
    logic [GPR_AW-1:0] rd;
    logic [GPR_DW-1:0] data;
    logic              ofen;
    logic              of;
  } wb_item;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

  function automatic wb_item make_item(input logic [GPR_AW-1:0] rd,
                                       input logic [GPR_DW-1:0] data,
                                       input logic              ofen,
                                       input logic              of);
    wb_item it;
    it.rd   = rd;
    it.data = data;
    it.ofen = ofen;
    it.of   = of;
    return it;
  endfunction

  // A trapping overflow suppresses the GPR write; r0 is never written.
  function automatic logic item_writes_gpr(input wb_item it);
    return (it.rd != '0) && !(it.ofen && it.of);
  endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// gpr_wb_fifo
// Synchronous FIFO of wb_item holding ALU results waiting for the write port.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties queue)
//   push, push_item : enqueue request and payload (ignored when full)
//   pop             : dequeue request (ignored when empty)
//   head_item       : oldest entry, valid while !empty
//   full, empty     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module gpr_wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  wb_item push_item,
  input  logic   pop,
  output wb_item head_item,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_item          mem_q [DEPTH];
  wb_item          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok;
  logic            pop_ok;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_item = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_item;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/gpr_wb.sv
// gpr_wb
// GPR write-back arbiter: merges returning loads and queued ALU results onto
// one registered GPR write port, tracks outstanding loads in a scoreboard and
// tells decode when to stall.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   alu_valid/alu_ready      : ALU result handshake (rd, data, ofen, of)
//   ld_issue, ld_issue_rd    : load issued; marks rd busy
//   ld_valid, ld_rd, ld_data : load data return (always accepted, priority)
//   rs_addr, rt_addr         : decode read addresses
//   busy_stall               : decode must stall
//   WrEn/WrAddr/WrData       : registered GPR write port
//   OFWrEn/OFFlag            : registered overflow-register write
//   rs/rt_fwd_hit, _data     : write-port bypass to decode
// Configuration macro: GPR_WB_BYPASS_EN enables the bypass outputs; without it
// the bypass is tied off and decode stalls on a write-port match instead.
module gpr_wb
  import gpr_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        alu_ofen,
  input  logic        alu_of,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        busy_stall,
  output logic        WrEn,
  output logic [4:0]  WrAddr,
  output logic [31:0] WrData,
  output logic        OFWrEn,
  output logic        OFFlag,
  output logic        rs_fwd_hit,
  output logic        rt_fwd_hit,
  output logic [31:0] rs_fwd_data,
  output logic [31:0] rt_fwd_data
);

  wb_item              fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  wb_src_e             sel_src;
  wb_item              sel_item;

  logic                wr_en_q, wr_en_d;
  logic [GPR_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [GPR_DW-1:0]   wr_data_q, wr_data_d;
  logic                of_wr_en_q, of_wr_en_d;
  logic                of_flag_q, of_flag_d;
  logic [31:0]         busy_q, busy_d;

  logic                rs_busy;
  logic                rt_busy;
  logic                of_hazard;
  logic                wb_hazard;

  // Ready is forced low during reset so nothing is accepted while the queue
  // is being cleared.
  assign alu_ready = !fifo_full && !rst;
  assign fifo_push = alu_valid && alu_ready;

  gpr_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_item(make_item(alu_rd, alu_data, alu_ofen, alu_of)),
    .pop      (fifo_pop),
    .head_item(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Loads cannot be back-pressured, so they always win the write port; the
  // ALU head waits in the queue and is popped only when it is selected.
  always_comb begin
    sel_src  = SRC_IDLE;
    sel_item = '0;
    fifo_pop = 1'b0;
    if (ld_valid) begin
      sel_src  = SRC_LOAD;
      sel_item = make_item(ld_rd, ld_data, 1'b0, 1'b0);
    end else if (!fifo_empty) begin
      sel_src  = SRC_ALU;
      sel_item = fifo_head;
      fifo_pop = 1'b1;
    end
  end

  // Address/data follow every selected item (even suppressed ones) and hold
  // through idle cycles; the enables pulse for one cycle per item.
  always_comb begin
    wr_en_d    = 1'b0;
    of_wr_en_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    of_flag_d  = of_flag_q;
    if (sel_src != SRC_IDLE) begin
      wr_en_d    = item_writes_gpr(sel_item);
      wr_addr_d  = sel_item.rd;
      wr_data_d  = sel_item.data;
      of_wr_en_d = (sel_src == SRC_ALU) && sel_item.ofen;
      of_flag_d  = (sel_src == SRC_ALU) && sel_item.ofen && sel_item.of;
    end
  end

  // Clear is applied before set so an issue and a return to the same rd in
  // one cycle leave the register busy for the newly issued load.
  always_comb begin
    busy_d = busy_q;
    if (ld_valid) begin
      busy_d[ld_rd] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != '0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      of_wr_en_q <= 1'b0;
      of_flag_q  <= 1'b0;
      busy_q     <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      of_wr_en_q <= of_wr_en_d;
      of_flag_q  <= of_flag_d;
      busy_q     <= busy_d;
    end
  end

  assign WrEn   = wr_en_q;
  assign WrAddr = wr_addr_q;
  assign WrData = wr_data_q;
  assign OFWrEn = of_wr_en_q;
  assign OFFlag = of_flag_q;

  assign rs_busy   = (rs_addr != '0) && busy_q[rs_addr];
  assign rt_busy   = (rt_addr != '0) && busy_q[rt_addr];
  // r30 is being rewritten by the overflow port this cycle.
  assign of_hazard = of_wr_en_q && ((rs_addr == OF_REG_IDX) || (rt_addr == OF_REG_IDX));

`ifdef GPR_WB_BYPASS_EN
  assign rs_fwd_hit  = wr_en_q && (rs_addr != '0) && (rs_addr == wr_addr_q);
  assign rt_fwd_hit  = wr_en_q && (rt_addr != '0) && (rt_addr == wr_addr_q);
  assign rs_fwd_data = wr_data_q;
  assign rt_fwd_data = wr_data_q;
  assign wb_hazard   = 1'b0;
`else
  // No bypass path: a read of the register being written right now stalls.
  assign rs_fwd_hit  = 1'b0;
  assign rt_fwd_hit  = 1'b0;
  assign rs_fwd_data = '0;
  assign rt_fwd_data = '0;
  assign wb_hazard   = wr_en_q && (((rs_addr != '0) && (rs_addr == wr_addr_q)) ||
                                   ((rt_addr != '0) && (rt_addr == wr_addr_q)));
`endif

  assign busy_stall = rs_busy || rt_busy || of_hazard || wb_hazard;

endmodule
